// File: rtl/lock_sequencer.sv
// Code-entry FSM for the digital lock: checks keypad digits against the code, times
// unlock/entry/lockout on ticks derived from the divided clock. Macro LOCK_CODE_PROG_EN adds code reprogramming.
module lock_sequencer #(
  parameter int DIGITS              = 4,
  parameter int DIGIT_W             = 4,
  parameter logic [DIGITS*DIGIT_W-1:0] CODE = 16'h1234,
  parameter int UNLOCK_TICKS        = 5,
  parameter int ENTRY_TIMEOUT_TICKS = 10,
  parameter int MAX_FAIL            = 3,
  parameter int LOCKOUT_TICKS       = 30
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          clkdiv_in,
  input  logic                          key_valid,
  input  logic [DIGIT_W-1:0]            key_code,
  input  logic                          key_clear,
  input  logic                          prog,
  output logic                          unlocked,
  output logic                          lockout,
  output logic                          error_pulse,
  output logic [$clog2(DIGITS+1)-1:0]   digit_count,
  output logic [$clog2(MAX_FAIL+1)-1:0] fail_count
);

  localparam int CW     = $clog2(DIGITS + 1);
  localparam int FW     = $clog2(MAX_FAIL + 1);
  localparam int CODE_W = DIGITS * DIGIT_W;
  localparam int T1     = (UNLOCK_TICKS > ENTRY_TIMEOUT_TICKS) ? UNLOCK_TICKS : ENTRY_TIMEOUT_TICKS;
  localparam int TMAX   = (T1 > LOCKOUT_TICKS) ? T1 : LOCKOUT_TICKS;
  localparam int TW     = $clog2(TMAX + 1);

  typedef enum logic [2:0] {S_IDLE, S_ENTRY, S_CHECK, S_UNLOCKED, S_ERROR, S_LOCKOUT} state_t;

  state_t               state;
  logic                 s1, s2, s3;
  logic                 tick;
  logic                 mismatch;
  logic [TW-1:0]        timer;
  logic [CODE_W-1:0]    active_code;
  logic [DIGIT_W-1:0]   code_digit;
  logic                 timer_run;

`ifdef LOCK_CODE_PROG_EN
  logic [CODE_W-1:0]    code_reg;
  logic [CODE_W-1:0]    new_code;
  logic [CW-1:0]        prog_count;
  assign active_code = code_reg;
  // The unlock timer stands still while a new code is being captured.
  assign timer_run   = tick & (prog_count == '0);
`else
  logic                 unused_prog;
  assign active_code = CODE;
  assign timer_run   = tick;
  assign unused_prog = prog;
`endif

  // The divided clock is only sampled; a rising edge becomes a one-cycle tick.
  assign tick = s2 & ~s3;

  // NOTE: always_comb gets a default before the loop so no path leaves code_digit unassigned (no latch).
  always_comb begin
    code_digit = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (digit_count == CW'(i)) code_digit = active_code[(DIGITS-1-i)*DIGIT_W +: DIGIT_W];
    end
  end

  // NOTE: all state updates use non-blocking assignments so every flop sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      s1          <= 1'b0;
      s2          <= 1'b0;
      s3          <= 1'b0;
      mismatch    <= 1'b0;
      timer       <= '0;
      unlocked    <= 1'b0;
      lockout     <= 1'b0;
      error_pulse <= 1'b0;
      digit_count <= '0;
      fail_count  <= '0;
`ifdef LOCK_CODE_PROG_EN
      code_reg    <= CODE;
      new_code    <= '0;
      prog_count  <= '0;
`endif
    end else begin
      s1          <= clkdiv_in;
      s2          <= s1;
      s3          <= s2;
      error_pulse <= 1'b0;
      case (state)
        S_IDLE: begin
          if (key_clear) begin
            digit_count <= '0;
          end else if (key_valid) begin
            state       <= S_ENTRY;
            mismatch    <= (key_code != code_digit);
            digit_count <= CW'(1);
            timer       <= '0;
          end
        end
        S_ENTRY: begin
          if (key_clear) begin
            state       <= S_IDLE;
            digit_count <= '0;
            timer       <= '0;
          end else if (key_valid) begin
            mismatch    <= mismatch | (key_code != code_digit);
            digit_count <= digit_count + CW'(1);
            timer       <= '0;
            if (digit_count == CW'(DIGITS - 1)) state <= S_CHECK;
          end else if (tick) begin
            if (timer == TW'(ENTRY_TIMEOUT_TICKS - 1)) begin
              state       <= S_IDLE;
              digit_count <= '0;
              timer       <= '0;
            end else begin
              timer <= timer + TW'(1);
            end
          end
        end
        S_CHECK: begin
          digit_count <= '0;
          timer       <= '0;
`ifdef LOCK_CODE_PROG_EN
          prog_count  <= '0;
`endif
          if (!mismatch) begin
            state      <= S_UNLOCKED;
            unlocked   <= 1'b1;
            fail_count <= '0;
          end else begin
            state       <= S_ERROR;
            error_pulse <= 1'b1;
            fail_count  <= fail_count + FW'(1);
          end
        end
        S_ERROR: begin
          if (fail_count == FW'(MAX_FAIL)) begin
            state   <= S_LOCKOUT;
            lockout <= 1'b1;
          end else begin
            state <= S_IDLE;
          end
        end
        S_UNLOCKED: begin
          if (key_clear) begin
            state    <= S_IDLE;
            unlocked <= 1'b0;
            timer    <= '0;
`ifdef LOCK_CODE_PROG_EN
          end else if (key_valid && (prog || prog_count != '0)) begin
            new_code <= {new_code[CODE_W-DIGIT_W-1:0], key_code};
            if (prog_count == CW'(DIGITS - 1)) begin
              code_reg   <= {new_code[CODE_W-DIGIT_W-1:0], key_code};
              prog_count <= '0;
              state      <= S_IDLE;
              unlocked   <= 1'b0;
              timer      <= '0;
            end else begin
              prog_count <= prog_count + CW'(1);
            end
`endif
          end else if (timer_run) begin
            if (timer == TW'(UNLOCK_TICKS - 1)) begin
              state    <= S_IDLE;
              unlocked <= 1'b0;
              timer    <= '0;
            end else begin
              timer <= timer + TW'(1);
            end
          end
        end
        S_LOCKOUT: begin
          if (tick) begin
            if (timer == TW'(LOCKOUT_TICKS - 1)) begin
              state      <= S_IDLE;
              lockout    <= 1'b0;
              fail_count <= '0;
              timer      <= '0;
            end else begin
              timer <= timer + TW'(1);
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lock_sequencer.sv
// Bench for lock_sequencer: randomized code entry against a digit-list reference model,
// with expected unlock/error/lockout events scoreboarded and matched by a monitor.
module tb_lock_sequencer;

  localparam int DIGITS              = 4;
  localparam int DIGIT_W             = 4;
  localparam logic [15:0] CODE       = 16'h1234;
  localparam int UNLOCK_TICKS        = 5;
  localparam int ENTRY_TIMEOUT_TICKS = 10;
  localparam int MAX_FAIL            = 3;
  localparam int LOCKOUT_TICKS       = 30;
  localparam int CW                  = $clog2(DIGITS + 1);
  localparam int FW                  = $clog2(MAX_FAIL + 1);

  logic               clk, rst, clkdiv_in, key_valid, key_clear, prog;
  logic [DIGIT_W-1:0] key_code;
  logic               unlocked, lockout, error_pulse;
  logic [CW-1:0]      digit_count;
  logic [FW-1:0]      fail_count;

  lock_sequencer #(
    .DIGITS(DIGITS), .DIGIT_W(DIGIT_W), .CODE(CODE), .UNLOCK_TICKS(UNLOCK_TICKS),
    .ENTRY_TIMEOUT_TICKS(ENTRY_TIMEOUT_TICKS), .MAX_FAIL(MAX_FAIL), .LOCKOUT_TICKS(LOCKOUT_TICKS)
  ) dut (
    .clk(clk), .rst(rst), .clkdiv_in(clkdiv_in), .key_valid(key_valid), .key_code(key_code),
    .key_clear(key_clear), .prog(prog), .unlocked(unlocked), .lockout(lockout),
    .error_pulse(error_pulse), .digit_count(digit_count), .fail_count(fail_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef enum int {EV_UNLOCK, EV_ERROR, EV_LOCKOUT} ev_kind_t;
  typedef struct {
    ev_kind_t kind;
    int       fails;
  } ev_t;

  ev_t sb_q[$];
  int  exp_code[DIGITS];
  int  digs[DIGITS];
  int  mf;
  bit  last_match;
  int  n_checks;
  int  n_pass;
  bit  mon_en;
  logic prev_unl, prev_lock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Monitor: every output event the DUT presents must match the next expected one.
  task automatic sb_match(input ev_kind_t got);
    ev_t e;
    check("sb_event_pending", 32'(sb_q.size() > 0), 1);
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check("sb_kind", got, e.kind);
      check("sb_fail_count", fail_count, e.fails);
    end
  endtask

  initial begin
    prev_unl  = 1'b0;
    prev_lock = 1'b0;
  end

  always @(negedge clk) begin
    if (mon_en) begin
      if (error_pulse) sb_match(EV_ERROR);
      if (unlocked && !prev_unl) sb_match(EV_UNLOCK);
      if (lockout && !prev_lock) sb_match(EV_LOCKOUT);
    end
    prev_unl  = unlocked;
    prev_lock = lockout;
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press(input int d, input bit with_clear);
    key_valid = 1'b1;
    key_code  = DIGIT_W'(d);
    key_clear = with_clear;
    step(1);
    key_valid = 1'b0;
    key_clear = 1'b0;
  endtask

  task automatic clear_pulse();
    key_clear = 1'b1;
    step(1);
    key_clear = 1'b0;
  endtask

  task automatic pulse();
    clkdiv_in = 1'b1;
    step(4);
    clkdiv_in = 1'b0;
    step(4);
  endtask

  task automatic set_digs(input int a, input int b, input int c, input int d);
    digs[0] = a; digs[1] = b; digs[2] = c; digs[3] = d;
  endtask

  // Reference model: a code is accepted iff every digit equals the stored code.
  task automatic enter_code();
    bit match;
    ev_t e;
    match = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      press(digs[i], 1'b0);
      if (digs[i] != exp_code[i]) match = 1'b0;
      if (i < DIGITS - 1) check("digit_count", digit_count, i + 1);
    end
    if (match) begin
      mf = 0;
      e.kind = EV_UNLOCK; e.fails = 0; sb_q.push_back(e);
    end else begin
      mf++;
      e.kind = EV_ERROR; e.fails = mf; sb_q.push_back(e);
      if (mf == MAX_FAIL) begin
        e.kind = EV_LOCKOUT; sb_q.push_back(e);
      end
    end
    @(negedge clk);
    check("early_unlocked", unlocked, 0);
    check("early_error", error_pulse, 0);
    @(negedge clk);
    check("unlocked_latency", unlocked, match);
    check("error_latency", error_pulse, !match);
    step(2);
    last_match = match;
  endtask

  task automatic finish_unlock(input int k);
    if (k >= UNLOCK_TICKS) begin
      repeat (UNLOCK_TICKS - 1) pulse();
      check("unlocked_before_expiry", unlocked, 1);
      pulse();
      check("unlocked_after_expiry", unlocked, 0);
    end else begin
      repeat (k) pulse();
      check("unlocked_before_clear", unlocked, 1);
      clear_pulse();
      @(negedge clk);
      check("unlocked_after_clear", unlocked, 0);
      step(1);
    end
  endtask

  task automatic recover_lockout(input bit probe);
    check("lockout_active", lockout, 1);
    if (probe) begin
      for (int i = 0; i < DIGITS; i++) press(exp_code[i], 1'b0);
      clear_pulse();
      step(2);
      check("lockout_keys_ignored", digit_count, 0);
      check("lockout_still_unlocked", unlocked, 0);
      check("lockout_clear_ignored", lockout, 1);
    end
    repeat (LOCKOUT_TICKS - 1) pulse();
    check("lockout_before_expiry", lockout, 1);
    pulse();
    check("lockout_after_expiry", lockout, 0);
    check("lockout_fail_reset", fail_count, 0);
    mf = 0;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int op, k;
    n_checks = 0; n_pass = 0; mf = 0; mon_en = 1'b0;
    rst = 1'b1; clkdiv_in = 1'b0; key_valid = 1'b0; key_clear = 1'b0; prog = 1'b0; key_code = '0;
    for (int i = 0; i < DIGITS; i++) exp_code[i] = int'((CODE >> ((DIGITS - 1 - i) * DIGIT_W)) & 16'hF);
    step(3);
    rst = 1'b0;
    step(1);
    mon_en = 1'b1;
    check("reset_unlocked", unlocked, 0);
    check("reset_lockout", lockout, 0);
    check("reset_error", error_pulse, 0);
    check("reset_digit_count", digit_count, 0);
    check("reset_fail_count", fail_count, 0);

    // Correct code, then expiry after UNLOCK_TICKS ticks.
    set_digs(1, 2, 3, 4);
    enter_code();
    finish_unlock(UNLOCK_TICKS);

    // Three wrong codes lead to lockout.
    for (int n = 0; n < MAX_FAIL; n++) begin
      set_digs(1, 2, 3, 5);
      enter_code();
      check("fail_count_step", fail_count, n + 1);
    end
    recover_lockout(1'b1);

    // Entry timeout discards partial input without counting a failure.
    press(1, 1'b0);
    press(2, 1'b0);
    repeat (ENTRY_TIMEOUT_TICKS - 1) pulse();
    check("timeout_not_yet", digit_count, 2);
    pulse();
    check("timeout_discard", digit_count, 0);
    check("timeout_no_fail", fail_count, 0);
    set_digs(1, 2, 3, 4);
    enter_code();
    finish_unlock(2);

    // Clear beats a simultaneous digit.
    press(1, 1'b0);
    press(2, 1'b1);
    step(3);
    check("clear_wins", digit_count, 0);
    check("clear_no_fail", fail_count, 0);

`ifdef LOCK_CODE_PROG_EN
    set_digs(1, 2, 3, 4);
    enter_code();
    prog = 1'b1;
    press(9, 1'b0);
    prog = 1'b0;
    press(8, 1'b0); press(7, 1'b0); press(6, 1'b0);
    step(1);
    check("prog_relock", unlocked, 0);
    exp_code[0] = 9; exp_code[1] = 8; exp_code[2] = 7; exp_code[3] = 6;
    set_digs(1, 2, 3, 4);
    enter_code();
    set_digs(9, 8, 7, 6);
    enter_code();
    finish_unlock(UNLOCK_TICKS);
`else
    set_digs(1, 2, 3, 4);
    enter_code();
    prog = 1'b1;
    press(9, 1'b0);
    prog = 1'b0;
    press(8, 1'b0); press(7, 1'b0); press(6, 1'b0);
    step(1);
    check("prog_ignored_unlocked", unlocked, 1);
    check("prog_ignored_count", digit_count, 0);
    finish_unlock(1);
`endif

    // Randomized sessions against the model.
    for (int it = 0; it < 40; it++) begin
      op = int'($urandom_range(0, 3));
      case (op)
        0, 1: begin
          for (int i = 0; i < DIGITS; i++)
            digs[i] = (op == 0 || $urandom_range(0, 1) == 1) ? exp_code[i] : int'($urandom_range(0, 15));
          enter_code();
          if (last_match) finish_unlock(int'($urandom_range(0, UNLOCK_TICKS)));
          else if (mf == MAX_FAIL) recover_lockout(1'($urandom_range(0, 1)));
        end
        2: begin
          k = int'($urandom_range(1, DIGITS - 1));
          for (int i = 0; i < k; i++) press(int'($urandom_range(0, 15)), 1'b0);
          check("rnd_partial_count", digit_count, k);
          repeat (ENTRY_TIMEOUT_TICKS) pulse();
          check("rnd_timeout_count", digit_count, 0);
        end
        default: begin
          k = int'($urandom_range(1, DIGITS - 1));
          for (int i = 0; i < k; i++) press(int'($urandom_range(0, 15)), 1'b0);
          if ($urandom_range(0, 1) == 1) press(int'($urandom_range(0, 15)), 1'b1);
          else clear_pulse();
          step(1);
          check("rnd_clear_count", digit_count, 0);
        end
      endcase
      check("rnd_fail_count", fail_count, mf);
    end

    // Reset during lockout and during unlock.
    while (mf < MAX_FAIL) begin
      for (int i = 0; i < DIGITS; i++) digs[i] = (exp_code[i] + 1) % 16;
      enter_code();
    end
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    mf = 0;
    check("rst_lockout", lockout, 0);
    check("rst_lockout_fail", fail_count, 0);
    for (int i = 0; i < DIGITS; i++) digs[i] = exp_code[i];
    enter_code();
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    check("rst_unlocked", unlocked, 0);
    check("rst_digit_count", digit_count, 0);

    for (int i = 0; i < 20 && sb_q.size() != 0; i++) step(1);
    check("sb_drained", sb_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/lock_sequencer.md
Name: lock_sequencer

Overview:
- Code-entry state machine for the digital lock, directly downstream of the frequency divider.
- Consumes the divider's slow square-wave output as its timebase and accepts digit strobes from the keypad front end.
- Decides unlock/error/lockout and drives the lock actuator and status outputs.
- Runs on the fast system clock; the divided clock is used only as a sampled timebase, never as a clock.

Parameters:
- DIGITS, 4, number of digits in the code (2..8)
- DIGIT_W, 4, bits per digit
- CODE, 16'h1234, default code, DIGITS*DIGIT_W bits; digit 0 is the most significant nibble
- UNLOCK_TICKS, 5, ticks the lock stays open
- ENTRY_TIMEOUT_TICKS, 10, idle ticks allowed between digits before entry is discarded
- MAX_FAIL, 3, consecutive failed codes before lockout
- LOCKOUT_TICKS, 30, lockout duration in ticks

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- clkdiv_in  in  1  divided clock from the frequency divider, asynchronous level
- key_valid  in  1  one-cycle digit strobe
- key_code  in  DIGIT_W  digit value, qualified by key_valid
- key_clear  in  1  one-cycle strobe: abort entry / relock
- prog  in  1  program request (used only with the optional feature)
- unlocked  out  1  actuator drive
- lockout  out  1  high during lockout
- error_pulse  out  1  one-cycle pulse per rejected code
- digit_count  out  $clog2(DIGITS+1)  digits entered so far
- fail_count  out  $clog2(MAX_FAIL+1)  consecutive failures

Behaviour:
- Clock and reset: one clock (clk); reset rst is synchronous and active-high.
- Reset values: state IDLE; all outputs 0; all counters 0; tick synchroniser flops 0.
- Tick generation:
  - clkdiv_in passes through a 2-flop synchroniser, then a third flop.
  - tick = s2 & ~s3, i.e. one-cycle pulse on each rising edge, 3 clk cycles after the edge.
  - If clkdiv_in is already high at reset release, one tick is produced; this is accepted behaviour.
- States: IDLE, ENTRY, CHECK, UNLOCKED, ERROR, LOCKOUT.
- IDLE:
  - key_valid → ENTRY.
  - The digit is compared against CODE digit 0; the mismatch flag is set if unequal; digit_count = 1.
- ENTRY:
  - Each key_valid compares against the digit at index digit_count; mismatch is sticky; digit_count increments.
  - When the DIGITS-th digit is accepted → CHECK.
  - Each tick increments the timeout counter; key_valid resets it to 0.
  - If the counter reaches ENTRY_TIMEOUT_TICKS → IDLE, digit_count = 0, fail_count unchanged.
- CHECK (1 cycle):
  - No mismatch → UNLOCKED; fail_count cleared.
  - Mismatch → ERROR.
- ERROR (1 cycle):
  - error_pulse = 1; fail_count increments.
  - If the new value equals MAX_FAIL → LOCKOUT, else → IDLE.
- UNLOCKED:
  - unlocked = 1; counts ticks; at UNLOCK_TICKS → IDLE.
  - key_clear → IDLE on the next cycle.
  - key_valid is ignored.
- LOCKOUT:
  - lockout = 1; key_valid and key_clear are ignored.
  - Counts ticks; at LOCKOUT_TICKS → IDLE with fail_count = 0.
- key_clear in IDLE or ENTRY: → IDLE, digit_count = 0, no fail counted.
- Outputs are registered (decoded from the next-state register):
  - unlocked rises 2 cycles after the clk edge sampling the final key_valid.
  - error_pulse follows the same 2-cycle latency.
- Simultaneous events:
  - key_clear with key_valid: clear wins, digit discarded.
  - tick with key_valid in ENTRY: key wins, timeout counter = 0.
  - tick in CHECK/ERROR: ignored.
- Counter widths sized by $clog2 of their limits; no wrap is possible because every counter resets on reaching its limit.
- rst mid-operation (including UNLOCKED or LOCKOUT): immediate return to reset values on the next edge.

Optional Feature:
- Macro: LOCK_CODE_PROG_EN
- Defined:
  - The active code is held in a register loaded from CODE at reset.
  - In UNLOCKED, prog=1 with key_valid starts capturing DIGITS new digits (MSB digit first). The unlock timer is frozen during capture.
  - The register is updated atomically after the last digit, then → IDLE.
  - key_clear aborts capture with the code unchanged.
- Undefined: the code is the constant CODE; prog is ignored.

Test Plan:
- Reset, then digits 1,2,3,4 with no ticks → unlocked=1 two cycles after the 4th strobe. After 5 rising edges of clkdiv_in, unlocked=0 and state returns to IDLE.
- Digits 1,2,3,5 three times → error_pulse three times; fail_count 1,2,3; lockout=1 after the 3rd. Keys during lockout are ignored. After 30 ticks, lockout=0 and fail_count=0.
- Digits 1,2 then 10 ticks with no keys → digit_count returns to 0, fail_count stays 0; then 1,2,3,4 → unlocked.
- key_valid and key_clear in the same cycle during ENTRY → digit_count=0, no error_pulse.
- Unlocked, then key_clear after 2 ticks → unlocked=0 next cycle.
- With LOCK_CODE_PROG_EN: unlock, prog+9,8,7,6 → then 1,2,3,4 gives error_pulse, and 9,8,7,6 unlocks.
